// File: rtl/rat_fetch_pkg.sv
// Shared types and constants for the RAT core instruction fetch unit.
package rat_fetch_pkg;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned INSTR_W = 18;
  localparam int unsigned STAT_W  = 16;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [STAT_W-1:0]  stat_t;

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_ISR = 1'b1
  } fetch_state_t;

  localparam addr_t RESET_ADDR  = 10'h000;
  localparam addr_t INTR_VECTOR = 10'h3FF;

  // Sequential successor address; wraps at the top of the address space.
  function automatic addr_t addr_inc(addr_t a);
    return a + addr_t'(1);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: pipeline control in, ROM port, IF/ID payload and interrupt status out.
interface fetch_unit_if;
  import rat_fetch_pkg::*;

  logic   stall;
  logic   redirect;
  addr_t  redirect_addr;
  logic   intr_req;
  logic   intr_done;
  addr_t  rom_addr;
  instr_t rom_data;
  instr_t instr_out;
  addr_t  addr_out;
  logic   valid_out;
  logic   intr_ack;
  addr_t  intr_ret_addr;
  stat_t  stat_fetch;
  stat_t  stat_bubble;

  modport master (
    input  stall, redirect, redirect_addr, intr_req, intr_done, rom_data,
    output rom_addr, instr_out, addr_out, valid_out, intr_ack, intr_ret_addr,
           stat_fetch, stat_bubble
  );

  modport slave (
    output stall, redirect, redirect_addr, intr_req, intr_done, rom_data,
    input  rom_addr, instr_out, addr_out, valid_out, intr_ack, intr_ret_addr,
           stat_fetch, stat_bubble
  );

endinterface

// File: rtl/fetch_pc_sel.sv
// Next-PC priority mux: reset, redirect, stall hold, interrupt vector, sequential.
module fetch_pc_sel
  import rat_fetch_pkg::*;
#(
  parameter addr_t RESET_ADDR  = rat_fetch_pkg::RESET_ADDR,
  parameter addr_t INTR_VECTOR = rat_fetch_pkg::INTR_VECTOR
) (
  input  logic  rst,
  input  logic  redirect,
  input  logic  stall,
  input  logic  intr_accept,
  input  addr_t redirect_addr,
  input  addr_t pc_q,
  output addr_t pc_d_c
);

  // Redirect wins over stall so a resolved branch is never lost behind a hold.
  always_comb begin
    pc_d_c = addr_inc(pc_q);
    if (rst) begin
      pc_d_c = RESET_ADDR;
    end else if (redirect) begin
      pc_d_c = redirect_addr;
    end else if (stall) begin
      pc_d_c = pc_q;
    end else if (intr_accept) begin
      pc_d_c = INTR_VECTOR;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RAT core fetch unit: PC, synchronous ROM addressing, redirect and single-level interrupt.
// Optional statistics counters are built when FETCH_STATS_EN is defined.
module fetch_unit
  import rat_fetch_pkg::*;
#(
  parameter addr_t RESET_ADDR  = rat_fetch_pkg::RESET_ADDR,
  parameter addr_t INTR_VECTOR = rat_fetch_pkg::INTR_VECTOR
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master fif
);

  addr_t        pc_q, pc_d;
  addr_t        ret_q, ret_d;
  fetch_state_t state_q, state_d;
  logic         intr_accept_c;
  logic         valid_c;

  // The ROM is addressed with the next PC so its registered output lines up with pc_q.
  fetch_pc_sel #(
    .RESET_ADDR  (RESET_ADDR),
    .INTR_VECTOR (INTR_VECTOR)
  ) u_pc_sel (
    .rst           (rst),
    .redirect      (fif.redirect),
    .stall         (fif.stall),
    .intr_accept   (intr_accept_c),
    .redirect_addr (fif.redirect_addr),
    .pc_q          (pc_q),
    .pc_d_c        (pc_d)
  );

  // Interrupt FSM; the return address skips pc_q because IF/ID latches it this cycle.
  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    intr_accept_c = 1'b0;
    if (state_q == ST_RUN) begin
      if (fif.intr_req && !fif.stall && !fif.redirect && !rst) begin
        intr_accept_c = 1'b1;
        ret_d         = addr_inc(pc_q);
        state_d       = ST_ISR;
      end
    end else begin
      if (fif.intr_done) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_ADDR;
      ret_q   <= '0;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      ret_q   <= ret_d;
      state_q <= state_d;
    end
  end

  // pc_q already holds RESET_ADDR in the first cycle rst is low, so that fetch is valid.
  assign valid_c = !rst;

  assign fif.rom_addr      = pc_d;
  assign fif.instr_out     = fif.rom_data;
  assign fif.addr_out      = pc_q;
  assign fif.valid_out     = valid_c;
  assign fif.intr_ack      = intr_accept_c;
  assign fif.intr_ret_addr = ret_q;

`ifdef FETCH_STATS_EN
  stat_t stat_fetch_q, stat_fetch_d;
  stat_t stat_bubble_q, stat_bubble_d;

  // Saturating event counters.
  always_comb begin
    stat_fetch_d  = stat_fetch_q;
    stat_bubble_d = stat_bubble_q;
    if (!fif.stall && valid_c && (stat_fetch_q != '1)) begin
      stat_fetch_d = stat_fetch_q + stat_t'(1);
    end
    if (fif.stall && (stat_bubble_q != '1)) begin
      stat_bubble_d = stat_bubble_q + stat_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetch_q  <= '0;
      stat_bubble_q <= '0;
    end else begin
      stat_fetch_q  <= stat_fetch_d;
      stat_bubble_q <= stat_bubble_d;
    end
  end

  assign fif.stat_fetch  = stat_fetch_q;
  assign fif.stat_bubble = stat_bubble_q;
`else
  assign fif.stat_fetch  = '0;
  assign fif.stat_bubble = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus interrupt and reset sequences.
module tb_fetch_unit;
  import rat_fetch_pkg::*;

  typedef struct {
    logic   rst;
    logic   stall;
    logic   redir;
    addr_t  raddr;
    logic   ireq;
    logic   idone;
    addr_t  e_addr;
    instr_t e_instr;
    logic   e_valid;
    addr_t  e_rom;
    logic   e_ack;
    addr_t  e_ret;
  } vec_t;

`ifdef FETCH_STATS_EN
  localparam int unsigned EXP_FETCH9  = 5;
  localparam int unsigned EXP_BUBBLE9 = 3;
`else
  localparam int unsigned EXP_FETCH9  = 0;
  localparam int unsigned EXP_BUBBLE9 = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  fetch_unit_if fif ();

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .fif (fif.master)
  );

  always #5 clk = ~clk;

  // ROM image: mem[i] = i + 0x100
  function automatic instr_t mem_f(addr_t a);
    return instr_t'(a) + instr_t'(18'h100);
  endfunction

  always @(posedge clk) fif.rom_data <= mem_f(fif.rom_addr);

  function automatic vec_t v(logic r, logic s, logic rd, addr_t ra, logic iq, logic id,
                             addr_t ea, instr_t ei, logic ev, addr_t er, logic ek, addr_t et);
    vec_t t;
    t.rst = r;  t.stall = s;  t.redir = rd; t.raddr = ra; t.ireq = iq; t.idone = id;
    t.e_addr = ea; t.e_instr = ei; t.e_valid = ev; t.e_rom = er; t.e_ack = ek; t.e_ret = et;
    return t;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
  endtask

  // Drive one cycle of inputs at the falling edge, check settled outputs 1 time unit later.
  task automatic run_vec(vec_t t, int idx);
    @(negedge clk);
    rst               = t.rst;
    fif.stall         = t.stall;
    fif.redirect      = t.redir;
    fif.redirect_addr = t.raddr;
    fif.intr_req      = t.ireq;
    fif.intr_done     = t.idone;
    #1;
    chk("addr_out",      idx, 32'(fif.addr_out),      32'(t.e_addr));
    chk("instr_out",     idx, 32'(fif.instr_out),     32'(t.e_instr));
    chk("valid_out",     idx, 32'(fif.valid_out),     32'(t.e_valid));
    chk("rom_addr",      idx, 32'(fif.rom_addr),      32'(t.e_rom));
    chk("intr_ack",      idx, 32'(fif.intr_ack),      32'(t.e_ack));
    chk("intr_ret_addr", idx, 32'(fif.intr_ret_addr), 32'(t.e_ret));
  endtask

  vec_t tbl [18];

  initial begin
    rst               = 1'b1;
    fif.stall         = 1'b0;
    fif.redirect      = 1'b0;
    fif.redirect_addr = '0;
    fif.intr_req      = 1'b0;
    fif.intr_done     = 1'b0;

    //            rst   stall redir raddr    ireq  idone addr     instr     valid rom      ack   ret
    tbl[0]  = v(1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 18'h100, 1'b0, 10'h000, 1'b0, 10'h000);
    tbl[1]  = v(1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 18'h100, 1'b1, 10'h001, 1'b0, 10'h000);
    tbl[2]  = v(1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h001, 18'h101, 1'b1, 10'h002, 1'b0, 10'h000);
    tbl[3]  = v(1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h002, 18'h102, 1'b1, 10'h003, 1'b0, 10'h000);
    tbl[4]  = v(1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h003, 18'h103, 1'b1, 10'h004, 1'b0, 10'h000);
    tbl[5]  = v(1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h004, 18'h104, 1'b1, 10'h005, 1'b0, 10'h000);
    tbl[6]  = v(1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 10'h005, 18'h105, 1'b1, 10'h005, 1'b0, 10'h000);
    tbl[7]  = v(1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 10'h005, 18'h105, 1'b1, 10'h005, 1'b0, 10'h000);
    tbl[8]  = v(1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 10'h005, 18'h105, 1'b1, 10'h005, 1'b0, 10'h000);
    tbl[9]  = v(1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h005, 18'h105, 1'b1, 10'h006, 1'b0, 10'h000);
    tbl[10] = v(1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h006, 18'h106, 1'b1, 10'h007, 1'b0, 10'h000);
    tbl[11] = v(1'b0, 1'b1, 1'b1, 10'h040, 1'b0, 1'b0, 10'h007, 18'h107, 1'b1, 10'h040, 1'b0, 10'h000);
    tbl[12] = v(1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h040, 18'h140, 1'b1, 10'h041, 1'b0, 10'h000);
    tbl[13] = v(1'b0, 1'b0, 1'b1, 10'h3FE, 1'b0, 1'b0, 10'h041, 18'h141, 1'b1, 10'h3FE, 1'b0, 10'h000);
    tbl[14] = v(1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h3FE, 18'h4FE, 1'b1, 10'h3FF, 1'b0, 10'h000);
    tbl[15] = v(1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h3FF, 18'h4FF, 1'b1, 10'h000, 1'b0, 10'h000);
    tbl[16] = v(1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 18'h100, 1'b1, 10'h001, 1'b0, 10'h000);
    tbl[17] = v(1'b0, 1'b0, 1'b1, 10'h020, 1'b0, 1'b0, 10'h001, 18'h101, 1'b1, 10'h020, 1'b0, 10'h000);

    repeat (2) @(posedge clk);

    // Reset, free run, 3-cycle stall, redirect over stall, wrap, redirect to 0x020
    for (int i = 0; i < 18; i++) begin
      run_vec(tbl[i], i);
      if (i == 9) begin
        chk("stat_fetch",  i, 32'(fif.stat_fetch),  32'(EXP_FETCH9));
        chk("stat_bubble", i, 32'(fif.stat_bubble), 32'(EXP_BUBBLE9));
      end
    end

    // Interrupt at 0x020, second request ignored in ISR, intr_done + redirect, re-accept
    run_vec(v(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h020, 18'h120, 1'b1, 10'h3FF, 1'b1, 10'h000), 100);
    run_vec(v(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h3FF, 18'h4FF, 1'b1, 10'h000, 1'b0, 10'h021), 101);
    run_vec(v(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 18'h100, 1'b1, 10'h001, 1'b0, 10'h021), 102);
    run_vec(v(1'b0, 1'b0, 1'b1, 10'h021, 1'b1, 1'b1, 10'h001, 18'h101, 1'b1, 10'h021, 1'b0, 10'h021), 103);
    run_vec(v(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h021, 18'h121, 1'b1, 10'h3FF, 1'b1, 10'h021), 104);
    run_vec(v(1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h3FF, 18'h4FF, 1'b1, 10'h000, 1'b0, 10'h022), 105);

    // Reset while in ISR with intr_req held; stall delays the post-reset accept by one cycle
    run_vec(v(1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 18'h100, 1'b0, 10'h000, 1'b0, 10'h022), 200);
    run_vec(v(1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 18'h100, 1'b0, 10'h000, 1'b0, 10'h000), 201);
    run_vec(v(1'b0, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 18'h100, 1'b1, 10'h000, 1'b0, 10'h000), 202);
    run_vec(v(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 18'h100, 1'b1, 10'h3FF, 1'b1, 10'h000), 203);
    run_vec(v(1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h3FF, 18'h4FF, 1'b1, 10'h000, 1'b0, 10'h001), 204);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
